divider_seq: RTL
================

# divider_seq

Sequential unsigned radix-2 restoring divider, the inverse of the datapath's pipelined multiplier. It takes a WIDTH_N-bit dividend and a WIDTH_D-bit divisor through a valid/ready input handshake and computes one quotient bit per cycle. It returns quotient, remainder and a divide-by-zero flag through a valid/ready output handshake. It sits in the DSP datapath wherever a product-width value must be scaled back down, such as normalisation or averaging.

## Interface
- WIDTH_N, 36, dividend and quotient width (matches multiplier product width)
- WIDTH_D, 18, divisor and remainder width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  dividend/divisor present
- in_ready  out  1  divider can accept an operation
- dividend  in  WIDTH_N  unsigned dividend N
- divisor  in  WIDTH_D  unsigned divisor D
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- quotient  out  WIDTH_N  Q = floor(N/D)
- remainder  out  WIDTH_D  R = N − Q·D
- div_by_zero  out  1  D was 0 for this result

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, the block latches N and D, clears the partial remainder (WIDTH_D+1 bits) and the bit counter, and moves to BUSY.
- BUSY: in_ready=0. Each cycle does one iteration:
  - shift {partial remainder, N} left 1;
  - trial = partial − D;
  - if trial ≥ 0, partial=trial and the shifted-in quotient bit is 1, else 0.
- The counter runs 0..WIDTH_N−1. The last iteration moves to DONE.
- DONE: out_valid=1, in_ready=0. Outputs hold stable until out_valid&&out_ready, then the FSM returns to IDLE.
- Divide by zero: the iteration runs normally with constant latency. In DONE, quotient is forced to all-ones, remainder to 0 and div_by_zero to 1.
- N<D: Q=0, R=N (exact, no special case).
- Only one operation is in flight. in_valid during BUSY/DONE is ignored (in_ready=0); the upstream holds.
- quotient/remainder/div_by_zero are registered. Outside DONE they hold their last value (0 after reset) and are don't-care to the consumer.
- Internal arithmetic is unsigned. The partial remainder is WIDTH_D+1 bits so the trial subtract never overflows. The final remainder takes the low WIDTH_D bits.

## Timing
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- Acceptance at edge E0 → BUSY for edges E1..E(WIDTH_N) → out_valid=1 after edge E(WIDTH_N). The default gives 36 cycles of latency.
- Result consumed at edge Ek (out_valid&&out_ready) → in_ready=1 after Ek. The next acceptance is at Ek+1 at the earliest, so peak throughput is one operation per WIDTH_N+2 cycles.
- out_ready has no combinational path to in_ready. All outputs are driven directly from registers.
- out_ready=1 before DONE has no effect. out_valid never drops without a handshake.
- rst_n asserted in BUSY or DONE aborts the operation immediately with no result. The block restarts in IDLE.

## Structure
- Shared DSP package holds:
  - the state typedef (IDLE/BUSY/DONE);
  - default WIDTH_N/WIDTH_D localparams, shared with the multiplier;
  - the counter width localparam $clog2(WIDTH_N).
- No sub-module. The FSM, counter and one-bit restoring step fit in a single module. The iteration step is a local function, not a separate instance.

## Test plan
- N=100, D=7, out_ready=1 → out_valid exactly 36 cycles after acceptance; Q=14, R=2, div_by_zero=0.
- N=2^36−1, D=2^18−1 → Q=262145, R=0. Then N=5, D=9 → Q=0, R=5.
- N=1234, D=0 → Q=all-ones (2^36−1), R=0, div_by_zero=1, same 36-cycle latency.
- N=1000, D=3, out_ready held 0 for 5 cycles after out_valid → Q=333, R=1 stable, in_ready=0 throughout. Releasing out_ready → in_ready=1 next cycle.
- Back-to-back: second in_valid asserted during BUSY → not accepted until after result handshake. Both results correct and in order.
- rst_n pulsed low at BUSY cycle 10 → all outputs return to reset values and no out_valid appears. A new op N=50, D=5 → Q=10, R=0.

Source files
------------

// File: rtl/divider_seq_pkg.sv
// ---------------------------------------------------------------------------
// divider_seq_pkg
//
// Purpose : Shared DSP datapath definitions for the sequential divider and
//           its companion pipelined multiplier.
//           - state_t     : divider control states (IDLE / BUSY / DONE)
//           - DEF_WIDTH_N : default dividend / quotient width, which equals
//                           the multiplier product width
//           - DEF_WIDTH_D : default divisor / remainder width
//           - DEF_CNT_W   : width of the iteration counter for DEF_WIDTH_N
// Ports   : none (package)
// ---------------------------------------------------------------------------
package divider_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH_N = 36;
   localparam int DEF_WIDTH_D = 18;
   localparam int DEF_CNT_W   = $clog2(DEF_WIDTH_N);

endpackage : divider_seq_pkg

// File: rtl/divider_seq.sv
// ---------------------------------------------------------------------------
// divider_seq
//
// Purpose : Sequential unsigned radix-2 restoring divider. It retires one
//           quotient bit per clock, so one operation takes WIDTH_N cycles
//           from acceptance to result. Only one operation is in flight at
//           a time.
//
// Ports   :
//   clk          in   1        rising-edge clock
//   rst_n        in   1        asynchronous active-low reset
//   in_valid     in   1        dividend/divisor present
//   in_ready     out  1        divider can accept an operation
//   dividend     in   WIDTH_N  unsigned dividend N
//   divisor      in   WIDTH_D  unsigned divisor D
//   out_valid    out  1        result present
//   out_ready    in   1        consumer accepts result
//   quotient     out  WIDTH_N  floor(N/D), all-ones when D == 0
//   remainder    out  WIDTH_D  N - Q*D, zero when D == 0
//   div_by_zero  out  1        D was 0 for this result
//
// Every output is a flop, so neither handshake has a combinational path
// from an input to an output.
// ---------------------------------------------------------------------------
module divider_seq
   import divider_seq_pkg::*;
#(
   parameter int WIDTH_N = DEF_WIDTH_N,
   parameter int WIDTH_D = DEF_WIDTH_D
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH_N-1:0] dividend,
   input  logic [WIDTH_D-1:0] divisor,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH_N-1:0] quotient,
   output logic [WIDTH_D-1:0] remainder,
   output logic               div_by_zero
);

   localparam int CNT_W = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_N - 1);

   // Result of one restoring iteration: updated partial remainder and the
   // dividend/quotient shift register with the new quotient bit in the LSB.
   typedef struct packed {
      logic [WIDTH_D:0]   partial;
      logic [WIDTH_N-1:0] acc;
   } step_t;

   // One restoring step. The partial remainder is always below D on entry,
   // so the shifted value is below 2*D and the difference taken when the
   // trial succeeds fits in WIDTH_D+1 bits.
   function automatic step_t div_step(
      input logic [WIDTH_D:0]   partial,
      input logic [WIDTH_N-1:0] acc,
      input logic [WIDTH_D-1:0] d
   );
      logic [WIDTH_D+1:0] shifted;
      logic [WIDTH_D:0]   diff;
      logic               ge;
      step_t              res;
      shifted     = {partial, acc[WIDTH_N-1]};
      ge          = (shifted >= (WIDTH_D+2)'(d));
      diff        = shifted[WIDTH_D:0] - {1'b0, d};
      res.partial = ge ? diff : shifted[WIDTH_D:0];
      res.acc     = {acc[WIDTH_N-2:0], ge};
      return res;
   endfunction

   state_t             state_reg;
   state_t             state_next;
   logic [WIDTH_N-1:0] acc_reg;
   logic [WIDTH_D-1:0] divisor_reg;
   logic [WIDTH_D:0]   partial_reg;
   logic [CNT_W-1:0]   cnt_reg;
   step_t              step;
   logic               last_iter;
   logic               zero_div;

   assign step      = div_step(partial_reg, acc_reg, divisor_reg);
   assign last_iter = (cnt_reg == CNT_LAST);
   assign zero_div  = (divisor_reg == '0);

   // -----------------------------------------------------------------------
   // Control FSM
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (last_iter) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Handshake flags follow the next state so they are valid the same
   // cycle the state register takes its new value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         in_ready  <= (state_next == IDLE);
         out_valid <= (state_next == DONE);
      end
   end

   // -----------------------------------------------------------------------
   // Datapath
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg     <= '0;
         divisor_reg <= '0;
         partial_reg <= '0;
         cnt_reg     <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  acc_reg     <= dividend;
                  divisor_reg <= divisor;
                  partial_reg <= '0;
                  cnt_reg     <= '0;
               end
            end
            BUSY: begin
               acc_reg     <= step.acc;
               partial_reg <= step.partial;
               cnt_reg     <= last_iter ? '0 : cnt_reg + 1'b1;
               // The result registers load only on the final iteration so
               // they hold steady for the whole DONE phase.
               if (last_iter) begin
                  quotient    <= zero_div ? '1 : step.acc;
                  remainder   <= zero_div ? '0 : step.partial[WIDTH_D-1:0];
                  div_by_zero <= zero_div;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule : divider_seq
